// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI master: register map, STATUS/CONFIG bit
// positions, engine state encoding and a bit-reversal helper.
package spi_master_pkg;

    localparam logic [3:0] ADDR_CS     = 4'd0;
    localparam logic [3:0] ADDR_DATA   = 4'd1;
    localparam logic [3:0] ADDR_STATUS = 4'd2;
    localparam logic [3:0] ADDR_CONFIG = 4'd3;
    localparam logic [3:0] ADDR_DIV    = 4'd4;

    localparam int ST_BUSY        = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_RX_EMPTY    = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_TX_OVERFLOW = 4;
    localparam int ST_DONE        = 7;

    localparam int CFG_CPOL      = 0;
    localparam int CFG_CPHA      = 1;
    localparam int CFG_LSB_FIRST = 2;
    localparam int CFG_IRQ_EN    = 3;

    typedef logic [0:0] engine_state_t;
    localparam engine_state_t STATE_IDLE  = 1'b0;
    localparam engine_state_t STATE_SHIFT = 1'b1;

    function automatic logic [7:0] reverse_byte(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO with combinational head; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module spi_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock_sys,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clock_sys) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clock_sys) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_master.sv
// Register-bus SPI master: programmable divider, four SPI modes, MSB/LSB
// order, TX/RX FIFOs and a completion interrupt.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int NUM_CS     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic              clock_sys,
    input  logic              reset,
    input  logic [3:0]        addr,
    input  logic [7:0]        data,
    input  logic              rw,
    input  logic              cs,
    input  logic              strobe,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic [NUM_CS-1:0] spi_cs,
    output logic [7:0]        data_out,
    output logic              data_out_en,
    output logic              irq
);
    logic                 wr, rd, status_clr;
    logic [NUM_CS-1:0]    cs_reg;
    logic                 cfg_cpol, cfg_cpha, cfg_lsb, cfg_irq_en;
    logic [DIV_WIDTH-1:0] div_reg;
    logic                 rx_overrun, tx_overflow, done, busy;
    engine_state_t        state;
    logic [7:0]           tx_sh, rx_sh, rx_raw, rx_byte;
    logic [3:0]           edge_cnt;
    logic [DIV_WIDTH-1:0] div_cnt, div_lat;
    logic                 cpha_lat, lsb_lat;
    logic                 tick, byte_done, sample_edge;
    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic                 rx_pop, rx_full, rx_empty;
    logic [7:0]           tx_head, rx_head;

    assign wr          = strobe && !cs && !rw;
    assign rd          = strobe && !cs && rw;
    assign status_clr  = wr && (addr == ADDR_STATUS);
    assign tx_push     = wr && (addr == ADDR_DATA);
    assign rx_pop      = rd && (addr == ADDR_DATA);
    assign tx_pop      = (state == STATE_IDLE) && !tx_empty;
    assign tick        = (state == STATE_SHIFT) && (div_cnt == div_lat);
    assign byte_done   = tick && (edge_cnt == 4'd15);
    assign sample_edge = (edge_cnt[0] == cpha_lat);
    assign busy        = (state != STATE_IDLE) || !tx_empty;
    // With CPHA=1 the final sample lands on the 16th edge itself.
    assign rx_raw      = cpha_lat ? {rx_sh[6:0], miso} : rx_sh;
    assign rx_byte     = lsb_lat ? reverse_byte(rx_raw) : rx_raw;
    assign spi_cs      = cs_reg;
    assign data_out_en = !cs && rw;
    assign irq         = cfg_irq_en && done;

    spi_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) tx_fifo (
        .clock_sys(clock_sys), .reset(reset),
        .push(tx_push), .wdata(data), .pop(tx_pop),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    spi_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) rx_fifo (
        .clock_sys(clock_sys), .reset(reset),
        .push(byte_done), .wdata(rx_byte), .pop(rx_pop),
        .rdata(rx_head), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clock_sys) begin
        if (reset) begin
            cs_reg     <= '1;
            cfg_cpol   <= 1'b0;
            cfg_cpha   <= 1'b0;
            cfg_lsb    <= 1'b0;
            cfg_irq_en <= 1'b0;
            div_reg    <= '0;
        end else if (wr) begin
            case (addr)
                ADDR_CS:     cs_reg <= data[NUM_CS-1:0];
                ADDR_CONFIG: {cfg_irq_en, cfg_lsb, cfg_cpha, cfg_cpol} <= data[3:0];
                ADDR_DIV:    div_reg <= data[DIV_WIDTH-1:0];
                default:     ;
            endcase
        end
    end

    // A new event in the same cycle as a write-1-clear keeps the flag set.
    always_ff @(posedge clock_sys) begin
        if (reset) begin
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
            done        <= 1'b0;
        end else begin
            rx_overrun  <= (byte_done && rx_full && !rx_pop) ||
                           (rx_overrun && !(status_clr && data[ST_RX_OVERRUN]));
            tx_overflow <= (tx_push && tx_full && !tx_pop) ||
                           (tx_overflow && !(status_clr && data[ST_TX_OVERFLOW]));
            done        <= (byte_done && tx_empty) ||
                           (done && !(status_clr && data[ST_DONE]));
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (addr)
            ADDR_CS:     data_out[NUM_CS-1:0] = cs_reg;
            ADDR_DATA:   data_out = rx_empty ? 8'h00 : rx_head;
            ADDR_STATUS: data_out = {done, 2'b00, tx_overflow, rx_overrun,
                                     rx_empty, tx_full, busy};
            ADDR_CONFIG: data_out = {4'h0, cfg_irq_en, cfg_lsb, cfg_cpha, cfg_cpol};
            ADDR_DIV:    data_out[DIV_WIDTH-1:0] = div_reg;
            default:     data_out = 8'h00;
        endcase
    end

    // LSB-first bytes are bit-reversed on load so the shifter always emits bit 7.
    always_ff @(posedge clock_sys) begin
        if (reset) begin
            state    <= STATE_IDLE;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            edge_cnt <= '0;
            div_cnt  <= '0;
            div_lat  <= '0;
            cpha_lat <= 1'b0;
            lsb_lat  <= 1'b0;
        end else if (state == STATE_IDLE) begin
            sck <= cfg_cpol;
            if (!tx_empty) begin
                tx_sh    <= cfg_lsb ? reverse_byte(tx_head) : tx_head;
                cpha_lat <= cfg_cpha;
                lsb_lat  <= cfg_lsb;
                div_lat  <= div_reg;
                div_cnt  <= '0;
                edge_cnt <= '0;
                if (!cfg_cpha) mosi <= cfg_lsb ? tx_head[0] : tx_head[7];
                state    <= STATE_SHIFT;
            end
        end else if (tick) begin
            div_cnt  <= '0;
            sck      <= ~sck;
            edge_cnt <= edge_cnt + 4'd1;
            if (sample_edge) begin
                rx_sh <= {rx_sh[6:0], miso};
            end else if (cpha_lat) begin
                mosi  <= tx_sh[7];
                tx_sh <= {tx_sh[6:0], 1'b0};
            end else if (edge_cnt != 4'd15) begin
                mosi  <= tx_sh[6];
                tx_sh <= {tx_sh[6:0], 1'b0};
            end
            if (edge_cnt == 4'd15) state <= STATE_IDLE;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a protocol monitor decodes mosi per SPI mode
// and a bus monitor checks DATA reads against queued expectations.
module tb_spi_master;
    import spi_master_pkg::*;

    localparam int NUM_CS     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_WIDTH  = 8;

    logic              clock_sys = 1'b0;
    logic              reset;
    logic [3:0]        addr;
    logic [7:0]        data;
    logic              rw, cs, strobe, miso;
    logic              mosi, sck, data_out_en, irq;
    logic [NUM_CS-1:0] spi_cs;
    logic [7:0]        data_out;

    logic       miso_loop  = 1'b1;
    logic       miso_const = 1'b0;
    logic       cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsb = 1'b0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         tests_run = 0, tests_failed = 0;
    int         sync_req = 0, sync_seen = 0;
    int         edge_cnt_mon = 0, rise_cnt = 0, mon_bits = 0;
    logic       prev_sck = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    int         model_rx_cnt = 0;
    logic       exp_overflow = 1'b0, exp_overrun = 1'b0;

    assign miso = miso_loop ? mosi : miso_const;

    always #5 clock_sys = ~clock_sys;

    spi_master #(.NUM_CS(NUM_CS), .FIFO_DEPTH(FIFO_DEPTH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clock_sys(clock_sys), .reset(reset), .addr(addr), .data(data),
        .rw(rw), .cs(cs), .strobe(strobe), .miso(miso), .mosi(mosi),
        .sck(sck), .spi_cs(spi_cs), .data_out(data_out),
        .data_out_en(data_out_en), .irq(irq)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Protocol monitor: an sck transition away from CPOL is leading; sample mosi on
    // the leading edge for CPHA=0 and the trailing edge for CPHA=1.
    always @(negedge clock_sys) begin
        logic [7:0] want;
        if (reset || sync_seen != sync_req) begin
            sync_seen = sync_req;
            prev_sck  = sck;
            mon_bits  = 0;
        end else if (sck !== prev_sck) begin
            edge_cnt_mon++;
            if (sck) rise_cnt++;
            if ((prev_sck == cur_cpol) != cur_cpha) begin
                if (cur_lsb) mon_byte[mon_bits] = mosi;
                else         mon_byte[7-mon_bits] = mosi;
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_bits = 0;
                    if (tx_exp.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL mosi_byte: actual 0x%0h, expected none", mon_byte);
                    end else begin
                        want = tx_exp.pop_front();
                        checkOutput("mosi_byte", 32'(mon_byte), 32'(want));
                    end
                end
            end
            prev_sck = sck;
        end
    end

    always @(negedge clock_sys) begin
        logic [7:0] want;
        if (!reset && strobe && !cs && rw && addr == ADDR_DATA) begin
            if (rx_exp.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL rx_data: actual 0x%0h, expected none", data_out);
            end else begin
                want = rx_exp.pop_front();
                checkOutput("rx_data", 32'(data_out), 32'(want));
            end
        end
    end

    task automatic busWrite(input logic [3:0] a, input logic [7:0] d);
        addr = a; data = d; rw = 1'b0; cs = 1'b0; strobe = 1'b1;
        @(posedge clock_sys); #1;
        strobe = 1'b0; cs = 1'b1; rw = 1'b1;
    endtask

    task automatic busRead(input logic [3:0] a);
        addr = a; rw = 1'b1; cs = 1'b0; strobe = 1'b1;
        @(posedge clock_sys); #1;
        strobe = 1'b0; cs = 1'b1;
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] v);
        addr = a; rw = 1'b1; cs = 1'b0; strobe = 1'b0;
        #1;
        v = data_out;
        cs = 1'b1;
    endtask

    task automatic setMode(input logic cpol, input logic cpha, input logic lsb,
                           input logic ien, input logic [7:0] div);
        busWrite(ADDR_CONFIG, {4'h0, ien, lsb, cpha, cpol});
        busWrite(ADDR_DIV, div);
        cur_cpol = cpol; cur_cpha = cpha; cur_lsb = lsb;
        repeat (2) @(posedge clock_sys);
        #1 sync_req++;
        @(posedge clock_sys); #1;
    endtask

    // Byte k of a burst started with the engine idle: the first goes straight to
    // the shifter, so FIFO_DEPTH+1 bytes fit before anything is dropped.
    task automatic sendByte(input logic [7:0] b, input int k);
        busWrite(ADDR_DATA, b);
        if (k <= FIFO_DEPTH) begin
            tx_exp.push_back(b);
            if (model_rx_cnt < FIFO_DEPTH) begin
                rx_exp.push_back(miso_loop ? b : {8{miso_const}});
                model_rx_cnt++;
            end else begin
                exp_overrun = 1'b1;
            end
        end else begin
            exp_overflow = 1'b1;
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) sendByte(8'($urandom_range(0, 255)), k);
    endtask

    task automatic drainRx(input int n);
        for (int i = 0; i < n; i++) begin
            busRead(ADDR_DATA);
            if (model_rx_cnt > 0) model_rx_cnt--;
        end
    endtask

    task automatic readEmpty();
        rx_exp.push_back(8'h00);
        busRead(ADDR_DATA);
    endtask

    task automatic waitIdle(output int cycles);
        addr = ADDR_STATUS; rw = 1'b1; cs = 1'b0; strobe = 1'b0;
        #1;
        cycles = 0;
        while (data_out[ST_BUSY] && cycles < 3000) begin
            @(posedge clock_sys); #1;
            cycles++;
        end
        if (cycles >= 3000) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL wait_idle: actual busy, expected idle within 3000 cycles");
        end
        cs = 1'b1;
    endtask

    function automatic logic [7:0] expStatus(input logic dn, input logic rxe);
        return {dn, 2'b00, exp_overflow, exp_overrun, rxe, 1'b0, 1'b0};
    endfunction

    initial begin
        logic [7:0] v;
        int cyc, base, guard, n;
        logic cpol, cpha, lsb;

        reset = 1'b1; addr = '0; data = '0; rw = 1'b1; cs = 1'b1; strobe = 1'b0;
        repeat (3) @(posedge clock_sys);
        #1 reset = 1'b0;

        checkOutput("reset_sck", 32'(sck), 32'd0);
        checkOutput("reset_mosi", 32'(mosi), 32'd0);
        checkOutput("reset_spi_cs", 32'(spi_cs), 32'hFF);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkOutput("reset_data_out_en", 32'(data_out_en), 32'd0);
        peek(ADDR_STATUS, v); checkOutput("reset_status", 32'(v), 32'h04);
        peek(ADDR_CONFIG, v); checkOutput("reset_config", 32'(v), 32'h00);
        peek(ADDR_DIV, v);    checkOutput("reset_div", 32'(v), 32'h00);

        busWrite(ADDR_CONFIG, 8'hFF);
        peek(ADDR_CONFIG, v); checkOutput("config_readback", 32'(v), 32'h0F);
        busWrite(ADDR_DIV, 8'h5A);
        peek(ADDR_DIV, v);    checkOutput("div_readback", 32'(v), 32'h5A);
        busWrite(4'd9, 8'h77);
        peek(4'd9, v);        checkOutput("unmapped_read", 32'(v), 32'h00);
        busWrite(ADDR_CS, 8'h3C);
        checkOutput("spi_cs_write", 32'(spi_cs), 32'h3C);
        addr = ADDR_CS; rw = 1'b1; cs = 1'b0; #1;
        checkOutput("cs_readback", 32'(data_out), 32'h3C);
        checkOutput("data_out_en_read", 32'(data_out_en), 32'd1);
        cs = 1'b1;
        busWrite(ADDR_CS, 8'hFF);

        // Mode 0, DIV=1, loopback, 0xA5
        miso_loop = 1'b1;
        setMode(1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        base = rise_cnt;
        sendByte(8'hA5, 0);
        waitIdle(cyc);
        checkOutput("mode0_busy_cycles", 32'(cyc), 32'd33);
        checkOutput("mode0_rising_edges", 32'(rise_cnt - base), 32'd8);
        peek(ADDR_STATUS, v); checkOutput("mode0_status", 32'(v), 32'h80);
        drainRx(1);

        // Mode 3, LSB first, DIV=0, miso tied high, 0x3C
        miso_loop = 1'b0; miso_const = 1'b1;
        setMode(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        checkOutput("mode3_sck_idle", 32'(sck), 32'd1);
        sendByte(8'h3C, 0);
        waitIdle(cyc);
        checkOutput("mode3_busy_cycles", 32'(cyc), 32'd17);
        checkOutput("mode3_sck_after", 32'(sck), 32'd1);
        drainRx(1);

        // Six back-to-back writes: overflow on the sixth, overrun on the fifth RX byte
        miso_loop = 1'b1;
        busWrite(ADDR_STATUS, 8'h98);
        setMode(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(6);
        waitIdle(cyc);
        peek(ADDR_STATUS, v); checkOutput("burst_status", 32'(v), 32'(expStatus(1'b1, 1'b0)));
        drainRx(FIFO_DEPTH);
        readEmpty();
        peek(ADDR_STATUS, v); checkOutput("burst_rx_empty", 32'(v[ST_RX_EMPTY]), 32'd1);
        busWrite(ADDR_STATUS, 8'h18);
        exp_overflow = 1'b0; exp_overrun = 1'b0;
        peek(ADDR_STATUS, v); checkOutput("sticky_clear", 32'(v), 32'(expStatus(1'b1, 1'b1)));

        // Interrupt
        busWrite(ADDR_STATUS, 8'h80);
        setMode(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        checkOutput("irq_before", 32'(irq), 32'd0);
        sendByte(8'($urandom_range(0, 255)), 0);
        waitIdle(cyc);
        checkOutput("irq_done", 32'(irq), 32'd1);
        busWrite(ADDR_STATUS, 8'h80);
        checkOutput("irq_cleared", 32'(irq), 32'd0);
        drainRx(1);

        // Randomized modes, dividers, byte counts and miso sources
        for (int it = 0; it < 10; it++) begin
            cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
            miso_loop = 1'($urandom); miso_const = 1'($urandom);
            n = $urandom_range(1, FIFO_DEPTH);
            setMode(cpol, cpha, lsb, 1'b0, 8'($urandom_range(0, 3)));
            applyStimulus(n);
            waitIdle(cyc);
            checkOutput("rand_sck_idle", 32'(sck), 32'(cpol));
            drainRx(n);
            peek(ADDR_STATUS, v);
            checkOutput("rand_status", 32'(v), 32'(expStatus(1'b1, 1'b1)));
        end

        // Reset in the middle of a byte
        miso_loop = 1'b1;
        setMode(1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        busWrite(ADDR_CS, 8'h00);
        checkOutput("spi_cs_low", 32'(spi_cs), 32'h00);
        base = edge_cnt_mon;
        tx_exp.push_back(8'h5A);
        busWrite(ADDR_DATA, 8'h5A);
        guard = 0;
        while (edge_cnt_mon - base < 7 && guard < 500) begin
            @(posedge clock_sys); #1;
            guard++;
        end
        if (guard >= 500) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL reset_wait: actual %0d edges, expected 7", edge_cnt_mon - base);
        end
        reset = 1'b1;
        @(posedge clock_sys); #1;
        reset = 1'b0;
        tx_exp.delete();
        model_rx_cnt = 0;
        cur_cpol = 1'b0; cur_cpha = 1'b0; cur_lsb = 1'b0;
        checkOutput("midreset_sck", 32'(sck), 32'd0);
        checkOutput("midreset_mosi", 32'(mosi), 32'd0);
        checkOutput("midreset_spi_cs", 32'(spi_cs), 32'hFF);
        peek(ADDR_STATUS, v); checkOutput("midreset_status", 32'(v), 32'h04);
        repeat (40) @(posedge clock_sys);
        #1;
        peek(ADDR_STATUS, v); checkOutput("midreset_no_rx", 32'(v), 32'h04);
        readEmpty();

        repeat (2) @(posedge clock_sys);
        checkOutput("tx_exp_drained", 32'(tx_exp.size()), 32'd0);
        checkOutput("rx_exp_drained", 32'(rx_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
